datapath_sequencer: RTL and testbench

Controller that sequences the register-bank / LFSR / ALU / display datapath from a single start command. It replaces hand-driven control with fixed multi-cycle sequences:
- LOAD: step the LFSR and write the random value to the next register.
- COMPUTE: run the ALU on the two most recently written registers and write the result back.

Each sequence ends by showing the written register on the display. It sits between the button/mode inputs and the datapath control pins in the top level.

---
 rtl/datapath_pkg.sv | 23 ++
 rtl/seq_ptr_unit.sv | 40 ++++
 rtl/datapath_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_datapath_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared types and encodings for the datapath sequencer: FSM states, command modes, ALU ops.
package datapath_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STEP    = 3'd1,
        S_WR_RAND = 3'd2,
        S_READ    = 3'd3,
        S_WR_ALU  = 3'd4,
        S_SHOW    = 3'd5,
        S_DONE    = 3'd6,
        S_ERR     = 3'd7
    } seq_state_t;

    localparam logic MODE_LOAD    = 1'b0;
    localparam logic MODE_COMPUTE = 1'b1;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

endpackage

// File: rtl/seq_ptr_unit.sv
// Write pointer, saturating fill count and the mod-NUM_REGS "recent register" addresses.
module seq_ptr_unit #(
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W:0]   fill_cnt,
    output logic [ADDR_W-1:0] ptr_m1,
    output logic [ADDR_W-1:0] ptr_m2
);

    localparam int unsigned NR = NUM_REGS;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   FILL_MAX = (ADDR_W + 1)'(NUM_REGS);

    // Explicit wrap so non-power-of-two register counts still index correctly.
    function automatic logic [ADDR_W-1:0] ptr_back(input logic [ADDR_W-1:0] p, input int unsigned k);
        int unsigned pv;
        pv = 32'(p);
        return (pv >= k) ? ADDR_W'(pv - k) : ADDR_W'(pv + NR - k);
    endfunction

    assign ptr_m1 = ptr_back(wr_ptr, 1);
    assign ptr_m2 = ptr_back(wr_ptr, 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            fill_cnt <= '0;
        end else if (inc) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (fill_cnt != FILL_MAX)
                fill_cnt <= fill_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Sequences LOAD (LFSR -> reg) and COMPUTE (ALU -> reg) commands, then shows the written register.
// Optional SEQ_AUTO_EN adds a periodic internal start (LOAD, LOAD, COMPUTE, ...).
//
// state   | meaning
// IDLE    | waiting for start; display source held
// STEP    | advance LFSR
// WR_RAND | write LFSR value to wr_ptr
// READ    | present rs1/rs2/op, let ALU settle
// WR_ALU  | write ALU result to wr_ptr
// SHOW    | display just-written register for DISP_CYCLES
// DONE    | done pulse
// ERR     | COMPUTE rejected (fewer than 2 valid registers)
module datapath_sequencer #(
    parameter int ADDR_W      = 5,
    parameter int NUM_REGS    = 32,
    parameter int DISP_CYCLES = 4,
    parameter int AUTO_PERIOD = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [1:0]        op_sel,
    output logic              mux_sel,
    output logic              we_reg,
    output logic              we_lfsr,
    output logic [ADDR_W-1:0] addr_rd,
    output logic [ADDR_W-1:0] addr_rs1,
    output logic [ADDR_W-1:0] addr_rs2,
    output logic [1:0]        alu_ctrl,
    output logic              disp_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W:0]   fill_cnt
);
    import datapath_pkg::*;

    localparam int CNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

    seq_state_t        state_q, state_d;
    logic              mode_q;
    logic [1:0]        op_q;
    logic [CNT_W-1:0]  show_cnt_q;
    logic [ADDR_W-1:0] rs2_hold_q;
    logic [ADDR_W-1:0] ptr_m1, ptr_m2;
    logic              ptr_inc;
    logic              cmd_start, cmd_mode;
    logic [1:0]        cmd_op;

`ifdef SEQ_AUTO_EN
    localparam int AUTO_W = $clog2(AUTO_PERIOD);

    logic [AUTO_W-1:0] auto_cnt_q;
    logic [1:0]        auto_phase_q;
    logic [1:0]        auto_op_q;
    logic              auto_start;

    assign auto_start = (auto_cnt_q == '0) && (state_q == S_IDLE);
    assign cmd_start  = start | auto_start;
    assign cmd_mode   = start ? mode   : ((auto_phase_q == 2'd2) ? MODE_COMPUTE : MODE_LOAD);
    assign cmd_op     = start ? op_sel : auto_op_q;

    // External start wins a collision; the pattern only advances on an accepted internal start.
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_cnt_q   <= AUTO_W'(AUTO_PERIOD - 1);
            auto_phase_q <= '0;
            auto_op_q    <= '0;
        end else begin
            auto_cnt_q <= (auto_cnt_q == '0) ? AUTO_W'(AUTO_PERIOD - 1) : auto_cnt_q - 1'b1;
            if (auto_start && !start) begin
                auto_phase_q <= (auto_phase_q == 2'd2) ? 2'd0 : auto_phase_q + 1'b1;
                if (auto_phase_q == 2'd2)
                    auto_op_q <= auto_op_q + 1'b1;
            end
        end
    end
`else
    assign cmd_start = start;
    assign cmd_mode  = mode;
    assign cmd_op    = op_sel;
`endif

    seq_ptr_unit #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (ptr_inc),
        .wr_ptr   (wr_ptr),
        .fill_cnt (fill_cnt),
        .ptr_m1   (ptr_m1),
        .ptr_m2   (ptr_m2)
    );

    always_comb begin
        state_d = state_q;
        ptr_inc = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    if (cmd_mode == MODE_LOAD)
                        state_d = S_STEP;
                    else if (fill_cnt >= (ADDR_W + 1)'(2))
                        state_d = S_READ;
                    else
                        state_d = S_ERR;
                end
            end
            S_STEP:    state_d = S_WR_RAND;
            S_WR_RAND: begin state_d = S_SHOW; ptr_inc = 1'b1; end
            S_READ:    state_d = S_WR_ALU;
            S_WR_ALU:  begin state_d = S_SHOW; ptr_inc = 1'b1; end
            S_SHOW:    if (show_cnt_q == '0) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            S_ERR:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_LOAD;
            op_q       <= '0;
            show_cnt_q <= '0;
            rs2_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            rs2_hold_q <= addr_rs2;
            if (state_q == S_IDLE && cmd_start) begin
                mode_q <= cmd_mode;
                op_q   <= cmd_op;
            end
            if (state_d == S_SHOW && state_q != S_SHOW)
                show_cnt_q <= CNT_W'(DISP_CYCLES - 1);
            else if (state_q == S_SHOW)
                show_cnt_q <= show_cnt_q - 1'b1;
        end
    end

    // Strobes are masked by rst so a write caught mid-sequence never lands on the reset edge.
    always_comb begin
        mux_sel  = 1'b0;
        we_reg   = 1'b0;
        we_lfsr  = 1'b0;
        addr_rd  = '0;
        addr_rs1 = '0;
        addr_rs2 = rs2_hold_q;
        alu_ctrl = '0;
        disp_en  = 1'b0;
        busy     = (state_q != S_IDLE);
        done     = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            S_STEP: we_lfsr = !rst;
            S_WR_RAND, S_WR_ALU: begin
                we_reg  = !rst;
                mux_sel = mode_q;
                addr_rd = wr_ptr;
                if (state_q == S_WR_ALU) begin
                    addr_rs1 = ptr_m2;
                    addr_rs2 = ptr_m1;
                    alu_ctrl = op_q;
                end
            end
            S_READ: begin
                addr_rs1 = ptr_m2;
                addr_rs2 = ptr_m1;
                alu_ctrl = op_q;
            end
            S_SHOW: begin
                disp_en  = 1'b1;
                addr_rs2 = ptr_m1;
            end
            S_DONE:  done = 1'b1;
            S_ERR:   err  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: transaction table plus hand-written corner sequences.
module tb_datapath_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, mode;
    logic [1:0] op_sel;
    logic       mux_sel, we_reg, we_lfsr, disp_en, busy, done, err;
    logic [4:0] addr_rd, addr_rs1, addr_rs2, wr_ptr;
    logic [1:0] alu_ctrl;
    logic [5:0] fill_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    datapath_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .op_sel(op_sel),
        .mux_sel(mux_sel), .we_reg(we_reg), .we_lfsr(we_lfsr), .addr_rd(addr_rd),
        .addr_rs1(addr_rs1), .addr_rs2(addr_rs2), .alu_ctrl(alu_ctrl), .disp_en(disp_en),
        .busy(busy), .done(done), .err(err), .wr_ptr(wr_ptr), .fill_cnt(fill_cnt)
    );

    typedef struct packed {
        logic       mux_sel, we_reg, we_lfsr;
        logic [4:0] addr_rd, addr_rs1, addr_rs2;
        logic [1:0] alu_ctrl;
        logic       disp_en, busy, done, err;
        logic [4:0] wr_ptr;
        logic [5:0] fill_cnt;
    } snap_t;

    typedef struct {
        logic       mode;
        logic [1:0] op;
        logic       exp_err;
        logic [4:0] rd, rs1, rs2r, wr0;
        logic [5:0] fill0;
        logic [4:0] wr1;
        logic [5:0] fill1;
        logic [4:0] prev_rs2;
    } txn_t;

    function automatic snap_t sample();
        snap_t s;
        s = '{mux_sel, we_reg, we_lfsr, addr_rd, addr_rs1, addr_rs2, alu_ctrl,
              disp_en, busy, done, err, wr_ptr, fill_cnt};
        return s;
    endfunction

    task automatic check(input string name, input snap_t exp);
        snap_t act;
        act = sample();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h (rd=%0d rs1=%0d rs2=%0d wr=%0d fill=%0d) expected %h (rd=%0d rs1=%0d rs2=%0d wr=%0d fill=%0d)",
                     name, act, act.addr_rd, act.addr_rs1, act.addr_rs2, act.wr_ptr, act.fill_cnt,
                     exp, exp.addr_rd, exp.addr_rs1, exp.addr_rs2, exp.wr_ptr, exp.fill_cnt);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one command and check every cycle through the return to IDLE.
    task automatic run_txn(input txn_t t, input string tag);
        snap_t e;
        @(negedge clk); start = 1'b1; mode = t.mode; op_sel = t.op;
        @(negedge clk); start = 1'b0; mode = 1'b0; op_sel = 2'd0;
        e = '0;
        e.busy = 1'b1; e.addr_rs2 = t.prev_rs2; e.wr_ptr = t.wr0; e.fill_cnt = t.fill0;
        if (t.exp_err) begin
            e.err = 1'b1;
            check({tag, "/err"}, e);
            @(negedge clk);
            e.err = 1'b0; e.busy = 1'b0;
            check({tag, "/err_idle"}, e);
        end else begin
            if (t.mode == 1'b0) begin
                e.we_lfsr = 1'b1;
                check({tag, "/step"}, e);
                @(negedge clk);
                e.we_lfsr = 1'b0; e.we_reg = 1'b1; e.addr_rd = t.rd;
                check({tag, "/wr_rand"}, e);
            end else begin
                e.addr_rs1 = t.rs1; e.addr_rs2 = t.rs2r; e.alu_ctrl = t.op;
                check({tag, "/read"}, e);
                @(negedge clk);
                e.we_reg = 1'b1; e.mux_sel = 1'b1; e.addr_rd = t.rd;
                check({tag, "/wr_alu"}, e);
            end
            e = '0;
            e.busy = 1'b1; e.disp_en = 1'b1; e.addr_rs2 = t.rd; e.wr_ptr = t.wr1; e.fill_cnt = t.fill1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check({tag, "/show"}, e);
            end
            @(negedge clk);
            e.disp_en = 1'b0; e.done = 1'b1;
            check({tag, "/done"}, e);
            @(negedge clk);
            e.done = 1'b0; e.busy = 1'b0;
            check({tag, "/idle"}, e);
        end
    endtask

    txn_t tbl[8];
    txn_t t;
    snap_t e;
    int done_seen;

    initial begin
        //          mode op  err rd rs1 rs2r wr0 fill0 wr1 fill1 prev
        tbl[0] = '{1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 5'd1, 6'd1, 5'd0};
        tbl[1] = '{1'b1, 2'd0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd1, 6'd1, 5'd1, 6'd1, 5'd0};
        tbl[2] = '{1'b0, 2'd0, 1'b0, 5'd1, 5'd0, 5'd0, 5'd1, 6'd1, 5'd2, 6'd2, 5'd0};
        tbl[3] = '{1'b1, 2'd0, 1'b0, 5'd2, 5'd0, 5'd1, 5'd2, 6'd2, 5'd3, 6'd3, 5'd1};
        tbl[4] = '{1'b1, 2'd1, 1'b0, 5'd3, 5'd1, 5'd2, 5'd3, 6'd3, 5'd4, 6'd4, 5'd2};
        tbl[5] = '{1'b0, 2'd2, 1'b0, 5'd4, 5'd0, 5'd0, 5'd4, 6'd4, 5'd5, 6'd5, 5'd3};
        tbl[6] = '{1'b1, 2'd3, 1'b0, 5'd5, 5'd3, 5'd4, 5'd5, 6'd5, 5'd6, 6'd6, 5'd4};
        tbl[7] = '{1'b1, 2'd2, 1'b0, 5'd6, 5'd4, 5'd5, 5'd6, 6'd6, 5'd7, 6'd7, 5'd5};

        rst = 1'b1; start = 1'b0; mode = 1'b0; op_sel = 2'd0;
        @(negedge clk); @(negedge clk);
        check("reset", '0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_txn(tbl[i], $sformatf("tbl%0d", i));

        // start pulsed during SHOW must be ignored, not queued
        done_seen = 0;
        @(negedge clk); start = 1'b1; mode = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = (k == 4);
            mode  = (k == 4);
            op_sel = (k == 4) ? 2'd1 : 2'd0;
            if (done === 1'b1) done_seen++;
        end
        check_val("ignored_start_done_count", done_seen, 1);
        e = '0; e.addr_rs2 = 5'd7; e.wr_ptr = 5'd8; e.fill_cnt = 6'd8;
        check("ignored_start_idle", e);

        // reset landing on WR_ALU
        @(negedge clk); start = 1'b1; mode = 1'b1; op_sel = 2'd2;
        @(negedge clk); start = 1'b0; mode = 1'b0; op_sel = 2'd0;
        @(negedge clk);
        e = '0; e.busy = 1'b1; e.we_reg = 1'b1; e.mux_sel = 1'b1; e.addr_rd = 5'd8;
        e.addr_rs1 = 5'd6; e.addr_rs2 = 5'd7; e.alu_ctrl = 2'd2; e.wr_ptr = 5'd8; e.fill_cnt = 6'd8;
        check("rst_pre_wr_alu", e);
        rst = 1'b1;
        #1 check_val("rst_cycle_we_reg", int'(we_reg), 0);
        @(negedge clk);
        check("rst_mid_seq", '0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_after", '0);

        // 33 LOADs: wrap of wr_ptr, fill_cnt saturation, then COMPUTE across the wrap
        for (int i = 0; i <= 32; i++) begin
            t.mode = 1'b0; t.op = 2'd0; t.exp_err = 1'b0;
            t.rd = 5'(i % 32); t.rs1 = 5'd0; t.rs2r = 5'd0;
            t.wr0 = 5'(i % 32); t.fill0 = 6'((i < 32) ? i : 32);
            t.wr1 = 5'((i + 1) % 32); t.fill1 = 6'((i + 1 < 32) ? i + 1 : 32);
            t.prev_rs2 = (i == 0) ? 5'd0 : 5'((i - 1) % 32);
            run_txn(t, $sformatf("load%0d", i));
        end
        t = '{1'b1, 2'd3, 1'b0, 5'd1, 5'd31, 5'd0, 5'd1, 6'd32, 5'd2, 6'd32, 5'd0};
        run_txn(t, "wrap_compute");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
